// File: rtl/kan_rslt_accumulator.sv
// kan_rslt_accumulator
// Folds the per-lane partial results of successive input-channel tiles of one
// KAN layer into a single result vector. Each tlast-delimited group of beats is
// summed per lane in a guard-extended accumulator, saturated to DATA_WIDTH and
// presented downstream as a one-beat packet.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where every valid bit and every ready bit of the vector is high. Partial
// valid or partial ready transfers nothing. The block drives its own ready and
// valid vectors as all-ones or all-zeros, never a mix.

module kan_rslt_accumulator #(
  parameter int LANES      = 256,
  parameter int DATA_WIDTH = 16,
  parameter int GUARD_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // Upstream partial results
  input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LANES-1:0]            s_axis_tvalid,
  output logic [LANES-1:0]            s_axis_tready,
  input  logic [LANES-1:0]            s_axis_tlast,
  // Downstream saturated sums
  output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [LANES-1:0]            m_axis_tvalid,
  input  logic [LANES-1:0]            m_axis_tready,
  output logic [LANES-1:0]            m_axis_tlast,
  // Sticky error flags, cleared only by rst
  output logic                        err_unaligned,
  output logic                        err_overflow,
  // Current FSM state for observation
  output logic [0:0]                  dbg_state_o
);

  localparam int ACC_W = DATA_WIDTH + GUARD_BITS;
  localparam int CNT_W = GUARD_BITS + 1;

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_OUTPUT = 1'b1;

  // Beat count at which the next accepted beat exceeds the legal group length
  localparam logic [CNT_W-1:0] CNT_LIMIT = {1'b1, {GUARD_BITS{1'b0}}};

  // Largest and smallest values representable in the result format,
  // expressed at accumulator width for signed comparison
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(GUARD_BITS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(GUARD_BITS + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]                        state_q, state_d;
  logic                              first_q, first_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              err_unaligned_q, err_unaligned_d;
  logic                              err_overflow_q, err_overflow_d;
  logic [LANES-1:0][ACC_W-1:0]       acc_q;
  logic [LANES*DATA_WIDTH-1:0]       m_data_q, m_data_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic in_accum;
  logic in_output;
  logic beat_acc;     // a full-width input beat is consumed this edge
  logic out_take;     // the pending output is consumed this edge
  logic grp_end;      // the consumed beat closes the group (lane 0 governs)
  logic tlast_mixed;  // consumed beat has a non-uniform tlast vector

  assign in_accum    = !rst && (state_q == ST_ACCUM);
  assign in_output   = !rst && (state_q == ST_OUTPUT);
  assign beat_acc    = in_accum && (&s_axis_tvalid);
  assign out_take    = in_output && (&m_axis_tready);
  assign grp_end     = beat_acc && s_axis_tlast[0];
  assign tlast_mixed = (|s_axis_tlast) && !(&s_axis_tlast);

  // ---------------------------------------------------------------------------
  // Per-lane datapath: sign extension, accumulate-or-load, saturation
  // ---------------------------------------------------------------------------
  logic [LANES-1:0][ACC_W-1:0] sample_ext;
  logic [LANES-1:0][ACC_W-1:0] acc_sum;
  logic [LANES*DATA_WIDTH-1:0] sat_val;

  // Compute the candidate accumulator value and its saturated result per lane
  always_comb begin : lane_math
    sample_ext = '0;
    acc_sum    = '0;
    sat_val    = '0;
    for (int i = 0; i < LANES; i++) begin
      sample_ext[i] = {{GUARD_BITS{s_axis_tdata[i*DATA_WIDTH + DATA_WIDTH - 1]}},
                       s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
      // The first beat of a group loads, later beats add with wrap at ACC_W
      acc_sum[i] = first_q ? sample_ext[i] : (acc_q[i] + sample_ext[i]);
      if ($signed(acc_sum[i]) > SAT_MAX) begin
        sat_val[i*DATA_WIDTH +: DATA_WIDTH] = OUT_MAX;
      end else if ($signed(acc_sum[i]) < SAT_MIN) begin
        sat_val[i*DATA_WIDTH +: DATA_WIDTH] = OUT_MIN;
      end else begin
        sat_val[i*DATA_WIDTH +: DATA_WIDTH] = acc_sum[i][DATA_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control next-state logic
  // ---------------------------------------------------------------------------

  // Sequence groups, count beats and raise sticky error conditions
  always_comb begin : ctrl_next
    state_d         = state_q;
    first_d         = first_q;
    cnt_d           = cnt_q;
    err_unaligned_d = err_unaligned_q;
    err_overflow_d  = err_overflow_q;
    m_data_d        = m_data_q;

    case (state_q)
      ST_ACCUM: begin
        if (beat_acc) begin
          first_d = 1'b0;
          if (first_q) begin
            cnt_d = {{(CNT_W - 1){1'b0}}, 1'b1};
          end else begin
            // Beats beyond the legal length are flagged; the counter holds at
            // the limit so that every further beat is also recognised as excess
            if (cnt_q == CNT_LIMIT) begin
              err_overflow_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (tlast_mixed) begin
            err_unaligned_d = 1'b1;
          end
          if (grp_end) begin
            state_d  = ST_OUTPUT;
            first_d  = 1'b1;
            cnt_d    = '0;
            m_data_d = sat_val;
          end
        end
      end
      ST_OUTPUT: begin
        if (out_take) begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        first_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control, error and output registers; reset discards any partial group
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_ACCUM;
      first_q         <= 1'b1;
      cnt_q           <= '0;
      err_unaligned_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      m_data_q        <= '0;
    end else begin
      state_q         <= state_d;
      first_q         <= first_d;
      cnt_q           <= cnt_d;
      err_unaligned_q <= err_unaligned_d;
      err_overflow_q  <= err_overflow_d;
      m_data_q        <= m_data_d;
    end
  end

  // Lane accumulators advance only on a consumed full-width beat
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (beat_acc) begin
      acc_q <= acc_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Ready and valid are masked by rst so both read low while reset is held,
  // and ready is visible in the very first cycle after rst drops.
  assign s_axis_tready = {LANES{in_accum}};
  assign m_axis_tvalid = {LANES{in_output}};
  assign m_axis_tlast  = {LANES{in_output}};
  assign m_axis_tdata  = m_data_q;
  assign err_unaligned = err_unaligned_q;
  assign err_overflow  = err_overflow_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_kan_rslt_accumulator.sv
// Self-checking bench for kan_rslt_accumulator (LANES=4, DATA_WIDTH=16,
// GUARD_BITS=4): reset values, a table of two-beat groups, hand sequences for
// the multi-cycle corner cases, and randomized groups against a sum model.

module tb_kan_rslt_accumulator;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int GB    = 4;
  localparam int W     = LANES * DW;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     s_data = '0;
  logic [LANES-1:0] s_valid = '0;
  logic [LANES-1:0] s_ready;
  logic [LANES-1:0] s_last = '0;
  logic [W-1:0]     m_data;
  logic [LANES-1:0] m_valid;
  logic [LANES-1:0] m_ready = '1;
  logic [LANES-1:0] m_last;
  logic             err_unaligned;
  logic             err_overflow;
  logic [0:0]       dbg_state;

  always #5 clk = ~clk;

  kan_rslt_accumulator #(
    .LANES(LANES), .DATA_WIDTH(DW), .GUARD_BITS(GB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_data),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tlast(s_last),
    .m_axis_tdata(m_data),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast(m_last),
    .err_unaligned(err_unaligned),
    .err_overflow(err_overflow),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check4(input string name, input logic [LANES-1:0] act, input logic [LANES-1:0] exp);
    check(name, W'(act), W'(exp));
  endtask

  function automatic logic [W-1:0] rep4(input logic [DW-1:0] v);
    return {v, v, v, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Outputs are sampled 1 time unit after the rising edge; inputs change there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one full-valid beat for one edge, then idle the input
  task automatic beat(input logic [W-1:0] d, input logic [LANES-1:0] last);
    s_data  = d;
    s_valid = '1;
    s_last  = last;
    tick;
    s_valid = '0;
    s_last  = '0;
  endtask

  // Compare the presented output, then let it be consumed with full ready
  task automatic take_output(input string name, input logic [W-1:0] exp);
    check4({name, " tvalid"}, m_valid, 4'hF);
    check({name, " tdata"}, m_data, exp);
    m_ready = '1;
    tick;
    check4({name, " tvalid drop"}, m_valid, 4'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Table of two-beat groups with hand-computed saturated sums
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] beat_a;
    logic [W-1:0] beat_b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[4];

  // ---------------------------------------------------------------------------
  // Reference model: plain integer sums clamped to the 16-bit range
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] clamp16(input int s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[DW-1:0];
  endfunction

  initial begin
    logic [W-1:0] hold_val;
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic signed [DW-1:0] samp;
    int sums[LANES];
    int n_beats;
    int bp;

    vecs[0] = '{ {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                 {16'h0040, 16'h0030, 16'h0020, 16'h0010},
                 {16'h0044, 16'h0033, 16'h0022, 16'h0011} };
    vecs[1] = '{ {16'h0000, 16'h0000, 16'h8000, 16'h7000},
                 {16'h0000, 16'h0000, 16'h8000, 16'h7000},
                 {16'h0000, 16'h0000, 16'h8000, 16'h7FFF} };
    vecs[2] = '{ {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001},
                 {16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF},
                 {16'h7FFF, 16'h8000, 16'h0000, 16'h0000} };
    vecs[3] = '{ {16'h1234, 16'hFFFE, 16'h4000, 16'hC000},
                 {16'h0000, 16'hFFFE, 16'h3FFF, 16'hC000},
                 {16'h1234, 16'hFFFC, 16'h7FFF, 16'h8000} };

    // ---- Reset values ----
    rst = 1'b1;
    tick;
    tick;
    check4("rst tready", s_ready, 4'h0);
    check4("rst tvalid", m_valid, 4'h0);
    check4("rst tlast", m_last, 4'h0);
    check("rst tdata", m_data, '0);
    check4("rst errs", {2'b00, err_unaligned, err_overflow}, 4'h0);
    rst = 1'b0;
    #1;
    check4("post-rst tready", s_ready, 4'hF);

    // ---- Basic sum ----
    beat(rep4(16'h1000), 4'h0);
    beat(rep4(16'h0800), 4'h0);
    beat(rep4(16'hFFFF), 4'hF);
    check4("basic tlast", m_last, 4'hF);
    check4("basic tready low", s_ready, 4'h0);
    check4("basic dbg_state", {3'b000, dbg_state}, 4'h1);
    take_output("basic", rep4(16'h17FF));
    check4("basic tready back", s_ready, 4'hF);

    // ---- Table of two-beat groups (includes saturation case) ----
    for (int i = 0; i < 4; i++) begin
      beat(vecs[i].beat_a, 4'h0);
      beat(vecs[i].beat_b, 4'hF);
      take_output($sformatf("vec%0d", i), vecs[i].exp);
    end
    check4("no errs after sat", {2'b00, err_unaligned, err_overflow}, 4'h0);

    // ---- Backpressure ----
    beat(rep4(16'h0ABC), 4'hF);
    hold_val = rep4(16'h0ABC);
    m_ready  = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      check4($sformatf("bp%0d tvalid", k), m_valid, 4'hF);
      check($sformatf("bp%0d tdata", k), m_data, hold_val);
      check4($sformatf("bp%0d tready", k), s_ready, 4'h0);
      tick;
    end
    m_ready = 4'hF;
    check4("bp5 tready", s_ready, 4'h0);
    take_output("bp5", hold_val);

    // ---- Partial valid ----
    s_data = rep4(16'h5555);
    s_last = 4'hF;
    for (int k = 0; k < 3; k++) begin
      s_valid = 4'b1011;
      tick;
      check4($sformatf("pv%0d no output", k), m_valid, 4'h0);
      check4($sformatf("pv%0d tready", k), s_ready, 4'hF);
    end
    beat(rep4(16'h0010), 4'hF);
    take_output("partial valid", rep4(16'h0010));

    // ---- Unaligned tlast ----
    beat(rep4(16'h0002), 4'b0100);
    check4("unaligned set", {3'b000, err_unaligned}, 4'h1);
    check4("unaligned group continues", m_valid, 4'h0);
    beat(rep4(16'h0003), 4'hF);
    take_output("unaligned sum", rep4(16'h0005));
    check4("unaligned sticky", {3'b000, err_unaligned}, 4'h1);

    // ---- Overflow: 17 beats of 1 ----
    for (int k = 0; k < 16; k++) beat(rep4(16'h0001), 4'h0);
    check4("ovf not at 16", {3'b000, err_overflow}, 4'h0);
    beat(rep4(16'h0001), 4'hF);
    check4("ovf at 17", {3'b000, err_overflow}, 4'h1);
    take_output("ovf sum", rep4(16'h0011));
    check4("errs sticky", {2'b00, err_unaligned, err_overflow}, 4'h3);

    // ---- Reset mid-group ----
    beat(rep4(16'h0100), 4'h0);
    beat(rep4(16'h0100), 4'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check4("midrst errs", {2'b00, err_unaligned, err_overflow}, 4'h0);
    beat(rep4(16'h0001), 4'hF);
    take_output("midrst", rep4(16'h0001));

    // ---- Randomized groups against the sum model ----
    for (int g = 0; g < 40; g++) begin
      n_beats = $urandom_range(1, 6);
      for (int l = 0; l < LANES; l++) sums[l] = 0;
      for (int b = 0; b < n_beats; b++) begin
        d = '0;
        for (int l = 0; l < LANES; l++) begin
          samp = DW'($urandom_range(0, 65535));
          d[l*DW +: DW] = samp;
          sums[l] += int'(samp);
        end
        // Occasionally a partial-valid cycle carrying junk that must be ignored
        if ($urandom_range(0, 2) == 0) begin
          s_valid = LANES'($urandom_range(0, 14));
          s_data  = {$urandom, $urandom};
          s_last  = 4'hF;
          tick;
          s_valid = '0;
        end
        beat(d, (b == n_beats - 1) ? 4'hF : 4'h0);
      end
      e = '0;
      for (int l = 0; l < LANES; l++) e[l*DW +: DW] = clamp16(sums[l]);
      exp_q.push_back(e);

      bp = $urandom_range(0, 3);
      for (int k = 0; k < bp; k++) begin
        m_ready = LANES'($urandom_range(0, 14));
        check($sformatf("rnd%0d hold%0d", g, k), m_data, exp_q[0]);
        tick;
      end
      take_output($sformatf("rnd%0d", g), exp_q.pop_front());
    end
    check4("rnd errs clear", {2'b00, err_unaligned, err_overflow}, 4'h0);

    // ---- Final report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
